// File: rtl/nexi_uart_rx_sampler_pkg.sv
// ============================================================================
// Module  : nexi_uart_pkg
// Brief   : Shared receive-side constants, FSM encoding and helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package nexi_uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 7;
    localparam int DATA_BITS  = 8;

    typedef enum logic [4:0] {
        RX_IDLE  = 5'b00001,
        RX_START = 5'b00010,
        RX_DATA  = 5'b00100,
        RX_STOP  = 5'b01000,
        RX_BREAK = 5'b10000
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nexi_uart_rx_sampler_if.sv
// ============================================================================
// Module  : nexi_uart_rx_sampler_if
// Brief   : Byte handshake and line status between receiver and consumer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface nexi_uart_rx_sampler_if;
    logic [7:0] data;
    logic       data_ready;
    logic       read_ack;
    logic       frame_err;
    logic       overrun;
    logic       rx_idle;

    modport master (
        output data, data_ready, frame_err, overrun, rx_idle,
        input  read_ack
    );

    modport slave (
        input  data, data_ready, frame_err, overrun, rx_idle,
        output read_ack
    );
endinterface

`default_nettype wire

// File: rtl/nexi_uart_baud_tick.sv
// ============================================================================
// Module  : nexi_uart_baud_tick
// Brief   : Divides clk_i by CLK_DIV into a one-cycle tick; clr holds phase.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nexi_uart_baud_tick #(
    parameter int CLK_DIV = 27
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic clr,
    output logic      tick
);

    localparam logic [15:0] C_LAST = 16'(CLK_DIV - 1);

    logic [15:0] r_cnt;

    assign tick = !clr && (r_cnt == C_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr || tick) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/nexi_uart_rx_sampler.sv
// ============================================================================
// Module  : nexi_uart_rx_sampler
// Brief   : 16x oversampling 8N1 deframer with data_ready/read_ack handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nexi_uart_rx_sampler
    import nexi_uart_pkg::*;
#(
    parameter int CLK_DIV     = 27,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    input  wire logic               rx_pin,
    nexi_uart_rx_sampler_if.master  rx_if
);

    logic [SYNC_STAGES-1:0] r_sync;
    rx_state_e              r_state;
    logic [3:0]             r_sample;
    logic [2:0]             r_bit;
    logic [3:0]             r_high;
    logic [1:0]             r_votes;
    logic [7:0]             r_shift;
    logic [7:0]             r_data;
    logic                   r_data_ready;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   r_rx_idle;

    logic w_rxs;
    logic w_tick;
    logic w_mid;
    logic w_vote;
    logic w_boundary;
    logic w_read_ack;

    assign w_rxs      = r_sync[SYNC_STAGES-1];
    assign w_read_ack = rx_if.read_ack;
    assign w_mid      = w_tick && (r_sample == 4'(SAMPLE_MID));
    assign w_vote     = w_tick && (r_sample == 4'(SAMPLE_MID + 1));
    assign w_boundary = w_tick && (r_sample == 4'(OVERSAMPLE - 1));

    // Holding the divider clear in IDLE aligns the sample phase to the start edge.
    nexi_uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (r_state == RX_IDLE),
        .tick  (w_tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_pin};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= RX_IDLE;
            r_sample     <= 4'd0;
            r_bit        <= 3'd0;
            r_high       <= 4'd0;
            r_votes      <= 2'b00;
            r_shift      <= 8'h00;
            r_data       <= 8'h00;
            r_data_ready <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_rx_idle    <= 1'b1;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_rx_idle   <= (r_state == RX_IDLE) && w_rxs;
            if (r_data_ready && w_read_ack) begin
                r_data_ready <= 1'b0;
            end
            if (w_tick) begin
                r_sample <= r_sample + 4'd1;
            end
            case (r_state)
                RX_IDLE: begin
                    r_sample <= 4'd0;
                    if (!w_rxs) begin
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_mid && w_rxs) begin
                        r_state <= RX_IDLE;
                    end else if (w_boundary) begin
                        r_state <= RX_DATA;
                        r_bit   <= 3'd0;
                    end
                end
                RX_DATA: begin
                    if (w_tick && (r_sample == 4'(SAMPLE_MID - 1))) begin
                        r_votes[0] <= w_rxs;
                    end
                    if (w_mid) begin
                        r_votes[1] <= w_rxs;
                    end
                    // Third vote is the live sample 8, so the shift lands one tick after mid-bit.
                    if (w_vote) begin
                        r_shift <= {majority3(r_votes[0], r_votes[1], w_rxs), r_shift[7:1]};
                    end
                    if (w_boundary) begin
                        if (r_bit == 3'(DATA_BITS - 1)) begin
                            r_state <= RX_STOP;
                        end
                        r_bit <= r_bit + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (w_mid) begin
                        if (w_rxs) begin
                            r_data       <= r_shift;
                            r_overrun    <= r_data_ready && !w_read_ack;
                            r_data_ready <= 1'b1;
                            r_state      <= RX_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_high      <= 4'd0;
                            r_state     <= RX_BREAK;
                        end
                    end
                end
                RX_BREAK: begin
                    if (w_tick) begin
                        if (!w_rxs) begin
                            r_high <= 4'd0;
                        end else if (r_high == 4'(OVERSAMPLE - 1)) begin
                            r_state <= RX_IDLE;
                        end else begin
                            r_high <= r_high + 4'd1;
                        end
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_if.data       = r_data;
    assign rx_if.data_ready = r_data_ready;
    assign rx_if.frame_err  = r_frame_err;
    assign rx_if.overrun    = r_overrun;
    assign rx_if.rx_idle    = r_rx_idle;

endmodule

`default_nettype wire

// File: tb/tb_nexi_uart_rx_sampler.sv
// ============================================================================
// Module  : tb_nexi_uart_rx_sampler
// Brief   : Scoreboard bench for the 8N1 receive sampler at CLK_DIV=4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nexi_uart_rx_sampler;

    localparam int BIT_CLKS = 64;

    typedef enum int {EV_BYTE = 0, EV_OVR = 1, EV_RELOAD = 2, EV_FE = 3} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] d;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic rx_pin;

    nexi_uart_rx_sampler_if bus();

    nexi_uart_rx_sampler #(
        .CLK_DIV     (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .rx_pin (rx_pin),
        .rx_if  (bus.master)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t         exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    bit          m_pending = 1'b0;
    int unsigned rise_cyc = 0;
    int unsigned lat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference model: what the consumer should see for each framed character.
    task automatic expect_frame(input logic [7:0] b, input bit stop_ok, input bit ack_at_load);
        ev_t e;
        e.d = b;
        if (!stop_ok) begin
            e.kind = EV_FE;
        end else begin
            if (m_pending && !ack_at_load)      e.kind = EV_OVR;
            else if (m_pending && ack_at_load)  e.kind = EV_RELOAD;
            else                                e.kind = EV_BYTE;
            m_pending = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    logic       prev_dr = 1'b0;
    logic [7:0] prev_d  = 8'h00;

    always @(negedge clk) begin
        ev_kind_e obs;
        ev_t      e;
        if (bus.frame_err || bus.overrun || (bus.data_ready && !prev_dr) ||
            (bus.data_ready && prev_dr && (bus.data !== prev_d))) begin
            if (bus.frame_err)       obs = EV_FE;
            else if (bus.overrun)    obs = EV_OVR;
            else if (!prev_dr)       obs = EV_BYTE;
            else                     obs = EV_RELOAD;
            if (obs == EV_BYTE) rise_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(obs), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", 32'(obs), 32'(e.kind));
                if (obs == EV_FE) begin
                    check("fe_ovr_exclusive", 32'(bus.overrun), 32'd0);
                end else begin
                    check("event_data", 32'(bus.data), 32'(e.d));
                    check("event_ready", 32'(bus.data_ready), 32'd1);
                end
            end
        end
        prev_dr <= bus.data_ready;
        prev_d  <= bus.data;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input bit stop);
        rx_pin = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            wait_clks(BIT_CLKS);
        end
        rx_pin = stop;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input bit ack_at_load);
        expect_frame(b, stop, ack_at_load);
        send_bits(b, stop);
    endtask

    task automatic consume();
        bus.read_ack = 1'b1;
        wait_clks(1);
        bus.read_ack = 1'b0;
        check("ack_clears_ready", 32'(bus.data_ready), 32'd0);
        m_pending = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n0;
        logic [7:0]  rb;
        bit          good;
        rst          = 1'b1;
        rx_pin       = 1'b1;
        bus.read_ack = 1'b0;
        wait_clks(5);
        check("reset_data",       32'(bus.data),       32'h00);
        check("reset_data_ready", 32'(bus.data_ready), 32'd0);
        check("reset_frame_err",  32'(bus.frame_err),  32'd0);
        check("reset_overrun",    32'(bus.overrun),    32'd0);
        check("reset_rx_idle",    32'(bus.rx_idle),    32'd1);
        rst = 1'b0;
        wait_clks(5);
        check("idle_after_reset", 32'(bus.rx_idle), 32'd1);

        // Plain byte receive and latency from the start edge
        n0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        lat = rise_cyc - n0;
        check("byte_a5_ready", 32'(bus.data_ready), 32'd1);
        check("byte_a5_data",  32'(bus.data),       32'hA5);
        check("latency_window", 32'((lat >= 600) && (lat <= 620)), 32'd1);
        consume();
        bus.read_ack = 1'b1;
        wait_clks(6);
        bus.read_ack = 1'b0;
        check("held_ack_no_effect", 32'(bus.data_ready), 32'd0);

        // Glitch shorter than half a bit
        rx_pin = 1'b0;
        wait_clks(20);
        rx_pin = 1'b1;
        wait_clks(100);
        check("glitch_idle",  32'(bus.rx_idle),    32'd1);
        check("glitch_ready", 32'(bus.data_ready), 32'd0);

        // Framing error followed by a held-low break
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clks(2 * 10 * BIT_CLKS);
        check("break_not_idle_low", 32'(bus.rx_idle), 32'd0);
        rx_pin = 1'b1;
        wait_clks(40);
        check("break_not_idle_yet", 32'(bus.rx_idle), 32'd0);
        wait_clks(50);
        check("break_idle_after",   32'(bus.rx_idle),    32'd1);
        check("break_no_ready",     32'(bus.data_ready), 32'd0);

        // Overrun
        send_frame(8'h11, 1'b1, 1'b0);
        wait_clks(BIT_CLKS);
        send_frame(8'h22, 1'b1, 1'b0);
        check("overrun_data", 32'(bus.data), 32'h22);
        consume();

        // Completion coincident with read_ack
        send_frame(8'h33, 1'b1, 1'b0);
        wait_clks(BIT_CLKS);
        n0 = cyc;
        fork
            send_frame(8'h55, 1'b1, 1'b1);
            begin
                while (cyc < n0 + lat - 1) @(negedge clk);
                bus.read_ack = 1'b1;
                wait_clks(1);
                bus.read_ack = 1'b0;
            end
        join
        check("simul_ready", 32'(bus.data_ready), 32'd1);
        check("simul_data",  32'(bus.data),       32'h55);
        consume();

        // Reset during data bit 4 of 0xFF
        rx_pin = 1'b0;
        wait_clks(BIT_CLKS);
        rx_pin = 1'b1;
        wait_clks(4 * BIT_CLKS + BIT_CLKS / 2);
        rst = 1'b1;
        wait_clks(3);
        check("midreset_ready",   32'(bus.data_ready), 32'd0);
        check("midreset_rx_idle", 32'(bus.rx_idle),    32'd1);
        rst = 1'b0;
        m_pending = 1'b0;
        wait_clks(200);
        send_frame(8'h0F, 1'b1, 1'b0);
        check("after_reset_data", 32'(bus.data), 32'h0F);
        consume();

        // Randomised traffic
        for (int k = 0; k < 16; k++) begin
            rb   = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            send_frame(rb, good, 1'b0);
            rx_pin = 1'b1;
            if (!good) wait_clks(80);
            wait_clks($urandom_range(0, 40));
            if (m_pending && ($urandom_range(0, 1) == 1)) consume();
        end

        wait_clks(100);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
